modexp_operand_loader: RTL
==========================

Name: modexp_operand_loader

Overview:
- Upstream/downstream wrapper for the modular-exponentiation FSM (x^y mod m).
- Accepts a 16-bit word stream from the host/trusted-IC link and assembles y_size, x, y and m.
- Pulses start to the exponentiator, captures its result on its ready pulse, and streams the result back as 16-bit words.
- Isolates the wide operand buses from the narrow off-chip interface.

Parameters:
KEY_LENGTH, 512, operand width in bits (x, m, result); multiple of WORD_WIDTH
E_WIDTH, 3, extra exponent bits; y width is KEY_LENGTH+E_WIDTH
WORD_WIDTH, 16, stream word width
TIMEOUT_CYCLES, 2**20, watchdog limit while waiting (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_data  in  WORD_WIDTH  inbound word
in_valid  in  1  inbound word valid
in_ready  out  1  loader accepts word (transfer = in_valid & in_ready)
exp_x  out  KEY_LENGTH  base to exponentiator
exp_y  out  KEY_LENGTH+E_WIDTH  exponent to exponentiator
exp_y_size  out  10  exponent bit size
exp_m  out  KEY_LENGTH  modulus
exp_start  out  1  one-cycle start pulse
exp_ready  in  1  exponentiator result-valid pulse
exp_out  in  KEY_LENGTH  exponentiator result
out_data  out  WORD_WIDTH  result word
out_valid  out  1  result word valid
out_ready  in  1  downstream accepts word
busy  out  1  high in every state except S_HDR
error  out  1  sticky watchdog flag (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs and operand registers go to 0; state goes to S_HDR; word counter goes to 0.
  - Reset mid-operation abandons the transaction; no exp_start follows.
- Constants: NW = KEY_LENGTH/WORD_WIDTH (32); NY = ceil((KEY_LENGTH+E_WIDTH)/WORD_WIDTH) (33).
- Inbound frame order: 1 header word, then NW x words, NY y words, NW m words. Total 98 words at default parameters.
- All operand words are sent least-significant word first.
- Header: exp_y_size = in_data[9:0]; upper header bits are ignored.
- The last y word contributes only its low (KEY_LENGTH+E_WIDTH) mod WORD_WIDTH bits; the rest are discarded.
- States:
  - S_HDR: in_ready=1. On transfer, latch y_size, clear counter, go to S_X.
  - S_X: in_ready=1. Each transfer writes word[cnt] and increments cnt. When cnt==NW-1 transfers, clear cnt and go to S_Y.
  - S_Y: same as S_X, ending at cnt==NY-1; go to S_M.
  - S_M: same as S_X, ending at cnt==NW-1; go to S_START.
  - S_START: exp_start=1 for exactly one cycle; go to S_WAIT.
  - S_WAIT: in_ready=0. On exp_ready=1, capture exp_out into the result register, clear cnt, go to S_OUT.
  - S_OUT: out_valid=1; out_data = result word[cnt]. On out_valid & out_ready, increment cnt. After word NW-1 is accepted, go to S_HDR next cycle.
- in_ready is 0 in S_START, S_WAIT and S_OUT; inbound words there are not consumed and are not lost by the sender.
- out_data holds steady while out_valid=1 and out_ready=0.
- exp_x/exp_y/exp_m/exp_y_size hold stable from S_START until the next S_HDR transfer.
- A one-cycle exp_ready arriving before S_WAIT (spurious) is ignored.
- Latency: exp_start is asserted the cycle after the final m word is accepted. out_valid is asserted the cycle after exp_ready is sampled in S_WAIT.
- in_valid gaps at any point are allowed; the counter advances only on a transfer.

Optional Feature:
- Macro: MODEXP_LOADER_TIMEOUT_EN.
- Defined:
  - A 32-bit watchdog counts cycles in S_WAIT.
  - At TIMEOUT_CYCLES without exp_ready: set error=1 (sticky until rst), drive out_valid with all-zero result words (NW words), then return to S_HDR.
- Undefined: no watchdog; S_WAIT waits indefinitely; error is tied to 0.

Decomposition:
- Shared package holds:
  - State enumeration S_HDR..S_OUT.
  - NW/NY word-count constants derived from KEY_LENGTH, E_WIDTH and WORD_WIDTH.
  - y_size field width (10).
- One sub-module is natural: word_pack_reg. It is a parameterised wide register with indexed word write (for x/y/m) and indexed word read (for the result), instantiated per operand.

Test Plan:
- Frame with y_size=3, x=3, y=5, m=7 (upper words 0); bench model returns 5 after 100 cycles:
  - exactly one exp_start cycle;
  - exp_x=3, exp_y=5, exp_m=7;
  - out words are 0x0005 followed by 31 words of 0x0000.
- Same frame with in_valid toggled every other cycle and out_ready held low for 10 cycles mid-unload:
  - identical operands and result;
  - out_data is stable while stalled.
- All-ones x, y and m: exp_y[514:512]=3'b111; bits above the E_WIDTH field in the final y word are discarded.
- Assert rst after 40 inbound words, then send a full new frame: no exp_start for the aborted frame; the new frame completes normally.
- in_valid held high during S_WAIT/S_OUT: in_ready=0 and no counter change; the next header word is accepted only after the last result word is accepted.
- With MODEXP_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=64, exp_ready never asserted: error=1 at cycle 64 of S_WAIT, 32 zero words out, state back to S_HDR.

Source files
------------

// File: rtl/modexp_operand_loader_pkg.sv
// Shared types and sizing helpers for the modexp operand loader.
package modexp_operand_loader_pkg;

    typedef enum logic [2:0] {
        S_HDR, S_X, S_Y, S_M, S_START, S_WAIT, S_OUT
    } state_t;

    localparam int YSIZE_W        = 10;
    localparam int KEY_LENGTH_DEF = 512;
    localparam int E_WIDTH_DEF    = 3;
    localparam int WORD_WIDTH_DEF = 16;

    // Number of stream words needed to carry a field of the given bit width.
    function automatic int words_for(input int bits, input int word_width);
        return (bits + word_width - 1) / word_width;
    endfunction

endpackage

// File: rtl/modexp_operand_loader_if.sv
// Host stream, exponentiator operand bus and result stream of the loader.
interface modexp_operand_loader_if #(
    parameter int KEY_LENGTH = 512,
    parameter int E_WIDTH    = 3,
    parameter int WORD_WIDTH = 16
);
    import modexp_operand_loader_pkg::*;

    logic [WORD_WIDTH-1:0]         in_data;
    logic                          in_valid;
    logic                          in_ready;
    logic [KEY_LENGTH-1:0]         exp_x;
    logic [KEY_LENGTH+E_WIDTH-1:0] exp_y;
    logic [YSIZE_W-1:0]            exp_y_size;
    logic [KEY_LENGTH-1:0]         exp_m;
    logic                          exp_start;
    logic                          exp_ready;
    logic [KEY_LENGTH-1:0]         exp_out;
    logic [WORD_WIDTH-1:0]         out_data;
    logic                          out_valid;
    logic                          out_ready;
    logic                          busy;
    logic                          error;

    modport slave (
        input  in_data, in_valid, exp_ready, exp_out, out_ready,
        output in_ready, exp_x, exp_y, exp_y_size, exp_m, exp_start,
               out_data, out_valid, busy, error
    );

    modport master (
        output in_data, in_valid, exp_ready, exp_out, out_ready,
        input  in_ready, exp_x, exp_y, exp_y_size, exp_m, exp_start,
               out_data, out_valid, busy, error
    );

endinterface

// File: rtl/modexp_operand_loader_word_pack_reg.sv
// Wide register filled one word at a time or loaded whole, read back one word at a time.
module word_pack_reg #(
    parameter int WIDTH      = 512,
    parameter int WORD_WIDTH = 16,
    parameter int IDX_W      = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic                  ld_en,
    input  logic [WIDTH-1:0]      ld_data,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [WORD_WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0]      q
);
    localparam int NWORDS = (WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;

    logic [WIDTH-1:0]                   nxt;
    logic [NWORDS-1:0][WORD_WIDTH-1:0] words;

    // The final word may be partial; its surplus input bits are dropped here.
    for (genvar i = 0; i < NWORDS; i++) begin : g_word
        localparam int LO = i * WORD_WIDTH;
        localparam int HI = (LO + WORD_WIDTH > WIDTH) ? WIDTH : LO + WORD_WIDTH;
        localparam int BW = HI - LO;
        assign nxt[HI-1:LO] = (wr_en && wr_idx == IDX_W'(i)) ? wr_data[BW-1:0] : q[HI-1:LO];
        assign words[i]     = WORD_WIDTH'(q[HI-1:LO]);
    end

    always_ff @(posedge clk) begin
        if (rst)        q <= '0;
        else if (ld_en) q <= ld_data;
        else            q <= nxt;
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NWORDS; i++)
            if (rd_idx == IDX_W'(i)) rd_data = words[i];
    end

endmodule

// File: rtl/modexp_operand_loader.sv
// Stream-to-operand loader and result unloader around the modexp engine.
// Optional watchdog in S_WAIT: define MODEXP_LOADER_TIMEOUT_EN.
module modexp_operand_loader
    import modexp_operand_loader_pkg::*;
#(
    parameter int KEY_LENGTH     = KEY_LENGTH_DEF,
    parameter int E_WIDTH        = E_WIDTH_DEF,
    parameter int WORD_WIDTH     = WORD_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic                    clk,
    input  logic                    rst,
    modexp_operand_loader_if.slave  bus
);
    localparam int NW = words_for(KEY_LENGTH, WORD_WIDTH);
    localparam int NY = words_for(KEY_LENGTH + E_WIDTH, WORD_WIDTH);
    localparam int CW = $clog2(NY) + 1;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [YSIZE_W-1:0] ysz;
    logic               in_rdy_q, out_vld_q, start_q, busy_q;
    logic               tmo;

    wire xfer    = bus.in_valid & in_rdy_q;
    wire last_nw = (cnt == CW'(NW - 1));
    wire last_ny = (cnt == CW'(NY - 1));
    wire wr_x    = xfer && state == S_X;
    wire wr_y    = xfer && state == S_Y;
    wire wr_m    = xfer && state == S_M;
    wire cap     = (state == S_WAIT) && (bus.exp_ready || tmo);

    // A watchdog expiry unloads an all-zero result instead of the engine output.
    wire [KEY_LENGTH-1:0] res_ld = tmo ? '0 : bus.exp_out;

    word_pack_reg #(.WIDTH(KEY_LENGTH), .WORD_WIDTH(WORD_WIDTH), .IDX_W(CW)) u_x (
        .clk(clk), .rst(rst), .wr_en(wr_x), .wr_idx(cnt), .wr_data(bus.in_data),
        .ld_en(1'b0), .ld_data('0), .rd_idx(cnt), .rd_data(), .q(bus.exp_x));

    word_pack_reg #(.WIDTH(KEY_LENGTH + E_WIDTH), .WORD_WIDTH(WORD_WIDTH), .IDX_W(CW)) u_y (
        .clk(clk), .rst(rst), .wr_en(wr_y), .wr_idx(cnt), .wr_data(bus.in_data),
        .ld_en(1'b0), .ld_data('0), .rd_idx(cnt), .rd_data(), .q(bus.exp_y));

    word_pack_reg #(.WIDTH(KEY_LENGTH), .WORD_WIDTH(WORD_WIDTH), .IDX_W(CW)) u_m (
        .clk(clk), .rst(rst), .wr_en(wr_m), .wr_idx(cnt), .wr_data(bus.in_data),
        .ld_en(1'b0), .ld_data('0), .rd_idx(cnt), .rd_data(), .q(bus.exp_m));

    word_pack_reg #(.WIDTH(KEY_LENGTH), .WORD_WIDTH(WORD_WIDTH), .IDX_W(CW)) u_res (
        .clk(clk), .rst(rst), .wr_en(1'b0), .wr_idx(cnt), .wr_data('0),
        .ld_en(cap), .ld_data(res_ld), .rd_idx(cnt), .rd_data(bus.out_data), .q());

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_HDR;
            cnt       <= '0;
            ysz       <= '0;
            in_rdy_q  <= 1'b0;
            out_vld_q <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                S_HDR: begin
                    in_rdy_q <= 1'b1;
                    if (xfer) begin
                        ysz    <= bus.in_data[YSIZE_W-1:0];
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= S_X;
                    end
                end
                S_X: if (xfer) begin
                    if (last_nw) begin cnt <= '0; state <= S_Y; end
                    else cnt <= cnt + 1'b1;
                end
                S_Y: if (xfer) begin
                    if (last_ny) begin cnt <= '0; state <= S_M; end
                    else cnt <= cnt + 1'b1;
                end
                S_M: if (xfer) begin
                    if (last_nw) begin
                        cnt      <= '0;
                        in_rdy_q <= 1'b0;
                        start_q  <= 1'b1;
                        state    <= S_START;
                    end else cnt <= cnt + 1'b1;
                end
                S_START: begin
                    start_q <= 1'b0;
                    state   <= S_WAIT;
                end
                S_WAIT: if (cap) begin
                    cnt       <= '0;
                    out_vld_q <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: if (bus.out_ready) begin
                    if (last_nw) begin
                        cnt       <= '0;
                        out_vld_q <= 1'b0;
                        busy_q    <= 1'b0;
                        in_rdy_q  <= 1'b1;
                        state     <= S_HDR;
                    end else cnt <= cnt + 1'b1;
                end
                default: state <= S_HDR;
            endcase
        end
    end

`ifdef MODEXP_LOADER_TIMEOUT_EN
    logic [31:0] wdog;
    logic        err_q;

    assign tmo = (state == S_WAIT) && !bus.exp_ready && (wdog == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog  <= '0;
            err_q <= 1'b0;
        end else begin
            wdog <= (state == S_WAIT) ? wdog + 32'd1 : '0;
            if (tmo) err_q <= 1'b1;
        end
    end

    assign bus.error = err_q;
`else
    assign tmo       = 1'b0;
    assign bus.error = 1'b0;
`endif

    assign bus.in_ready   = in_rdy_q;
    assign bus.out_valid  = out_vld_q;
    assign bus.exp_start  = start_q;
    assign bus.exp_y_size = ysz;
    assign bus.busy       = busy_q;

endmodule
